jtframe_mixer_seq: RTL
======================

# jtframe_mixer_seq

Time-multiplexed N-channel sound mixer for the jtframe sound path, successor to the fixed four-input combinational mixer. It snapshots all channel samples on each sample strobe and runs one multiply-accumulate per clock with CPU-programmable per-channel gains and per-channel mute. The result is saturated and emitted with a sample pulse, and a held peak indicator is provided. It sits after the chip cores (FM, PCM, PSG) and feeds the board-level audio output.

## Interface
- CH, 4: channel count, 1..8
- W, 16: signed input sample width, all channels
- WOUT, 16: signed output width
- GW, 8: unsigned gain width, fixed point with 4 fractional bits (8'h10 = 1.0)
- GAIN_RST, 8'h10: reset value of every gain register
- PEAK_HOLD, 1023: number of samples the peak flag is held after the last clip

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  sample-rate strobe; starts a mix sequence
- ch  in  CH*W  packed signed samples; channel k is ch[k*W +: W]
- mute  in  CH  per-channel mute, sampled at capture
- gain_we  in  1  gain register write strobe
- gain_sel  in  3  gain register index
- gain_din  in  GW  gain write data
- mixed  out  WOUT  signed saturated mix
- sample  out  1  one-clock pulse when mixed updates
- peak  out  1  clip indicator, held
- busy  out  1  sequence in progress
- overrun  out  1  sticky; a cen arrived while busy

## Operation
- FSM states: IDLE, MAC, SAT.
- IDLE → MAC on cen:
  - Captures the ch and gain banks into snapshot registers.
  - Muted channels are captured as 0.
  - Clears the accumulator and sets index k=0.
- MAC: each clock adds ch_snap[k] × gain_snap[k] to the accumulator.
  - The gain is zero-extended before the multiply; the product is signed.
  - k increments each clock. After k=CH-1 the FSM moves to SAT.
- SAT, one clock:
  - Computes acc >>> 4 (arithmetic shift, floor).
  - Clamps the result to [-2^(WOUT-1), 2^(WOUT-1)-1] and registers it to mixed.
  - Pulses sample.
  - Returns to IDLE.
- Accumulator width is W+GW+clog2(CH)+1, so it never overflows internally.
- Peak behaviour:
  - If the SAT clamp is active, peak is set to 1 and the hold counter is loaded with PEAK_HOLD.
  - Otherwise, if the counter is nonzero it decrements; peak clears on the SAT cycle in which the counter reaches 0.
- Gain writes:
  - gain_we with gain_sel<CH writes gain[gain_sel] that clock.
  - gain_sel≥CH is ignored.
  - A write affects only sequences captured afterwards; the sequence in flight uses its snapshot.
  - A write on the capture clock is not seen by that capture.
- cen while busy: dropped, no restart, and overrun is set. overrun clears only on rst.

## Timing
- cen at clock t:
  - capture at t.
  - MAC occupies t+1..t+CH.
  - SAT at t+CH+1.
  - mixed and sample are valid from t+CH+2 (sample high exactly one clock).
- busy is high from t+1 through t+CH+1 inclusive.
- The minimum cen period without overrun is CH+2 clocks.
- Reset values: mixed=0, sample=0, peak=0, busy=0, overrun=0, state IDLE, all gains=GAIN_RST, hold counter=0.
- rst mid-sequence aborts immediately: no sample pulse, and mixed stays 0.
- rst has priority over cen and gain_we on the same clock.

## Structure
- Package jtframe_mixer_pkg holds:
  - the state enum (IDLE/MAC/SAT);
  - GAIN_FRAC=4;
  - GAIN_ONE=8'h10.
- Sub-module jtframe_sat: parametrised signed saturating truncation from width WI to WO, with a clip flag output.
- MAC, FSM, gain bank and peak counter all live in jtframe_mixer_seq.

## Test plan
- Unity gain. CH=4; ch0=16'h1000, gain0=8'h10, other gains 0; single cen. Expect mixed=16'h1000, sample at t+6, peak=0.
- Fractional gain. ch1=16'h1000, gain1=8'h03, others muted. Expect mixed=16'h0300. With ch1=-1 the result is mixed=-1 (floor).
- Saturation both signs.
  - ch0=ch1=16'h7000 at unity: expect 16'h7FFF with peak=1.
  - ch0=ch1=-16'h7000: expect 16'h8000.
- Peak hold with PEAK_HOLD=3. One clipped sample followed by clean samples: peak stays high through the 3rd clean SAT and is low after.
- Gain write during MAC. Write gain0=0 at t+2: the current sample is unaffected. The next cen uses 0. A write to gain_sel=5 with CH=4 changes nothing.
- Overrun and reset.
  - cen at t and t+3: the second cen is ignored, overrun=1, and only one sample pulse occurs.
  - rst at t+3: no pulse, all outputs at reset values, gains restored to 8'h10.

Source files
------------

// File: rtl/jtframe_mixer_pkg.sv
// Shared constants and FSM state encoding for the sequential jtframe sound mixer.
package jtframe_mixer_pkg;
  localparam int         GAIN_FRAC = 4;
  localparam logic [7:0] GAIN_ONE  = 8'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2
  } mix_state_e;
endpackage

// File: rtl/jtframe_sat.sv
// Signed saturating truncation from WI to WO bits; clip flags a clamped value.
module jtframe_sat #(
  parameter int WI = 24,
  parameter int WO = 16
) (
  input  logic signed [WI-1:0] din,
  output logic signed [WO-1:0] dout,
  output logic                 clip
);
  generate
    if (WI > WO) begin : g_trunc
      // In range only when every bit from WO-1 upward matches the sign bit
      logic [WI-WO:0] hi;
      assign hi = din[WI-1:WO-1];
      always_comb begin
        clip = !((&hi) || !(|hi));
        dout = din[WO-1:0];
        if (clip) dout = din[WI-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
      end
    end else begin : g_ext
      assign dout = WO'(din);
      assign clip = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/jtframe_mixer_seq.sv
// Time-multiplexed CH-channel mixer: snapshot on cen, one MAC per clock,
// then a saturating shift to WOUT with a held peak (clip) indicator.
module jtframe_mixer_seq
  import jtframe_mixer_pkg::*;
#(
  parameter int          CH        = 4,
  parameter int          W         = 16,
  parameter int          WOUT      = 16,
  parameter int          GW        = 8,
  parameter logic [GW-1:0] GAIN_RST = GW'(GAIN_ONE),
  parameter int          PEAK_HOLD = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [CH*W-1:0]   ch,
  input  logic [CH-1:0]     mute,
  input  logic              gain_we,
  input  logic [2:0]        gain_sel,
  input  logic [GW-1:0]     gain_din,
  output logic [WOUT-1:0]   mixed,
  output logic              sample,
  output logic              peak,
  output logic              busy,
  output logic              overrun
);
  localparam int KW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = W + GW + $clog2(CH) + 1;
  localparam int PW = W + GW + 1;
  localparam int SW = AW - GAIN_FRAC;
  localparam int HW = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;

  mix_state_e               state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [CH-1:0][W-1:0]     ch_snap_q, ch_snap_d;
  logic [CH-1:0][GW-1:0]    gain_snap_q, gain_snap_d;
  logic [CH-1:0][GW-1:0]    gain_q, gain_d;
  logic [WOUT-1:0]          mixed_q, mixed_d;
  logic                     sample_q, sample_d;
  logic                     peak_q, peak_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic                     overrun_q, overrun_d;

  logic signed [PW-1:0]     op_a, op_b, prod;
  logic signed [SW-1:0]     shifted;
  logic signed [WOUT-1:0]   sat_out;
  logic                     clip;

  // Gain is zero-extended so 8'hFF means +15.9375, never negative
  assign op_a    = PW'($signed(ch_snap_q[k_q]));
  assign op_b    = $signed(PW'({1'b0, gain_snap_q[k_q]}));
  assign prod    = op_a * op_b;
  assign shifted = acc_q[AW-1:GAIN_FRAC];

  jtframe_sat #(.WI(SW), .WO(WOUT)) u_sat (
    .din  (shifted),
    .dout (sat_out),
    .clip (clip)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    ch_snap_d   = ch_snap_q;
    gain_snap_d = gain_snap_q;
    gain_d      = gain_q;
    mixed_d     = mixed_q;
    sample_d    = 1'b0;
    peak_d      = peak_q;
    hold_d      = hold_q;
    overrun_d   = overrun_q;

    for (int i = 0; i < CH; i++)
      if (gain_we && gain_sel == 3'(i)) gain_d[i] = gain_din;

    if (cen && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: if (cen) begin
        for (int i = 0; i < CH; i++)
          ch_snap_d[i] = mute[i] ? '0 : ch[i*W +: W];
        gain_snap_d = gain_q;
        acc_d       = '0;
        k_d         = '0;
        state_d     = MAC;
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(CH-1)) state_d = SAT;
      end
      SAT: begin
        mixed_d  = sat_out;
        sample_d = 1'b1;
        state_d  = IDLE;
        if (clip) begin
          peak_d = 1'b1;
          hold_d = HW'(PEAK_HOLD);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) peak_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      ch_snap_q   <= '0;
      gain_snap_q <= '0;
      gain_q      <= {CH{GAIN_RST}};
      mixed_q     <= '0;
      sample_q    <= 1'b0;
      peak_q      <= 1'b0;
      hold_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      ch_snap_q   <= ch_snap_d;
      gain_snap_q <= gain_snap_d;
      gain_q      <= gain_d;
      mixed_q     <= mixed_d;
      sample_q    <= sample_d;
      peak_q      <= peak_d;
      hold_q      <= hold_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mixed   = mixed_q;
  assign sample  = sample_q;
  assign peak    = peak_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;
endmodule
